// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_arb_pkg
// Description : Shared types and constants for the two-port multiplier-cell
//               arbiter and its partial-product combiner.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = DATA_W / 2;

    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COMBINE = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mult_pp_combine.sv
`default_nettype none
// ============================================================================
// Module      : mult_pp_combine
// Description : Folds the lo*lo, lo*hi and hi*lo partial products of a
//               16x16 cell into the low DATA_W bits of a full product.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_pp_combine
    import mult_arb_pkg::*;
(
    input  logic [DATA_W-1:0] i_p1,
    input  logic [DATA_W-1:0] i_p2,
    input  logic [DATA_W-1:0] i_p3,
    output logic [DATA_W-1:0] o_product
);

    logic [DATA_W-1:0] w_cross;

    // hi*hi only lands at bit 32 and above, so it never contributes here.
    always_comb begin
        w_cross   = i_p2 + i_p3;
        o_product = i_p1 + (w_cross << HALF_W);
    end

endmodule
`default_nettype wire

// File: rtl/mult_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_cell_arbiter
// Description : Round-robin sharing of one 16x16 partial-product multiplier
//               cell between two valid/ready requesters, one op in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_cell_arbiter
    import mult_arb_pkg::*;
#(
    parameter int MUL_LAT = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              busy,
    output logic [DATA_W-1:0] mul_src1,
    output logic [DATA_W-1:0] mul_src2,
    output logic              mul_en,
    input  logic [DATA_W-1:0] mul_p1,
    input  logic [DATA_W-1:0] mul_p2,
    input  logic [DATA_W-1:0] mul_p3
);

    localparam int CNT_W = 3;

    generate
        if (MUL_LAT < 1 || MUL_LAT > 4) begin : g_lat_check
            $error("mult_cell_arbiter: MUL_LAT must be in 1..4");
        end
    endgenerate

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_last_grant;
    logic              r_id;
    logic              r_rsp_id;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_mul_src1;
    logic [DATA_W-1:0] r_mul_src2;
    logic [DATA_W-1:0] r_rsp_result;
    logic [DATA_W-1:0] w_product;
    logic              w_any_req;
    logic              w_grant_id;
    logic              w_accept;

    assign w_any_req = req0_valid | req1_valid;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        w_grant_id = REQ_ID_0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = REQ_ID_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        mul_en       = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req && !reset) begin
                    w_accept     = 1'b1;
                    req0_ready   = (w_grant_id == REQ_ID_0);
                    req1_ready   = (w_grant_id == REQ_ID_1);
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mul_en = 1'b1;
                if (r_wait_cnt == CNT_W'(1)) begin
                    w_next_state = ST_COMBINE;
                end
            end
            ST_COMBINE: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_src1   <= '0;
            r_mul_src2   <= '0;
            r_id         <= REQ_ID_0;
            r_last_grant <= REQ_ID_1;
            r_wait_cnt   <= '0;
            r_rsp_result <= '0;
            r_rsp_id     <= REQ_ID_0;
        end else begin
            if (w_accept) begin
                r_mul_src1   <= (w_grant_id == REQ_ID_1) ? req1_src1 : req0_src1;
                r_mul_src2   <= (w_grant_id == REQ_ID_1) ? req1_src2 : req0_src2;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_wait_cnt   <= CNT_W'(MUL_LAT);
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end
            // Cell enable is low here, so its products are frozen.
            if (r_state == ST_COMBINE) begin
                r_rsp_result <= w_product;
                r_rsp_id     <= r_id;
            end
        end
    end

    mult_pp_combine u_combine (
        .i_p1      (mul_p1),
        .i_p2      (mul_p2),
        .i_p3      (mul_p3),
        .o_product (w_product)
    );

    assign mul_src1   = r_mul_src1;
    assign mul_src2   = r_mul_src2;
    assign rsp_result = r_rsp_result;
    assign rsp_id     = r_rsp_id;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_cell_arbiter
// Description : Directed bench; instance a uses MUL_LAT=1, instance b MUL_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_cell_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_reset, a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_id, a_busy, a_mul_en;
    logic [31:0] a_req0_src1, a_req0_src2, a_req1_src1, a_req1_src2;
    logic [31:0] a_rsp_result, a_mul_src1, a_mul_src2;
    logic [31:0] a_mul_p1 = '0, a_mul_p2 = '0, a_mul_p3 = '0;

    logic        b_reset, b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_busy, b_mul_en;
    logic [31:0] b_req0_src1, b_req0_src2, b_req1_src1, b_req1_src2;
    logic [31:0] b_rsp_result, b_mul_src1, b_mul_src2;
    logic [31:0] b_mul_p1, b_mul_p2, b_mul_p3;
    logic [31:0] b_pipe [3][3] = '{default: '0};

    mult_cell_arbiter #(.MUL_LAT(1)) dut_a (
        .clk(clk), .reset(a_reset),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready),
        .req0_src1(a_req0_src1), .req0_src2(a_req0_src2),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready),
        .req1_src1(a_req1_src1), .req1_src2(a_req1_src2),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
        .rsp_result(a_rsp_result), .busy(a_busy),
        .mul_src1(a_mul_src1), .mul_src2(a_mul_src2), .mul_en(a_mul_en),
        .mul_p1(a_mul_p1), .mul_p2(a_mul_p2), .mul_p3(a_mul_p3)
    );

    mult_cell_arbiter #(.MUL_LAT(3)) dut_b (
        .clk(clk), .reset(b_reset),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
        .req0_src1(b_req0_src1), .req0_src2(b_req0_src2),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
        .req1_src1(b_req1_src1), .req1_src2(b_req1_src2),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_result(b_rsp_result), .busy(b_busy),
        .mul_src1(b_mul_src1), .mul_src2(b_mul_src2), .mul_en(b_mul_en),
        .mul_p1(b_mul_p1), .mul_p2(b_mul_p2), .mul_p3(b_mul_p3)
    );

    // Cell models: unsigned 16x16 products, advanced only while enabled.
    always @(posedge clk) begin
        if (a_mul_en) begin
            a_mul_p1 <= {16'h0, a_mul_src1[15:0]}  * {16'h0, a_mul_src2[15:0]};
            a_mul_p2 <= {16'h0, a_mul_src1[15:0]}  * {16'h0, a_mul_src2[31:16]};
            a_mul_p3 <= {16'h0, a_mul_src1[31:16]} * {16'h0, a_mul_src2[15:0]};
        end
    end

    always @(posedge clk) begin
        if (b_mul_en) begin
            b_pipe[0][0] <= {16'h0, b_mul_src1[15:0]}  * {16'h0, b_mul_src2[15:0]};
            b_pipe[0][1] <= {16'h0, b_mul_src1[15:0]}  * {16'h0, b_mul_src2[31:16]};
            b_pipe[0][2] <= {16'h0, b_mul_src1[31:16]} * {16'h0, b_mul_src2[15:0]};
            b_pipe[1]    <= b_pipe[0];
            b_pipe[2]    <= b_pipe[1];
        end
    end
    assign b_mul_p1 = b_pipe[2][0];
    assign b_mul_p2 = b_pipe[2][1];
    assign b_mul_p3 = b_pipe[2][2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_reset = 1'b1; b_reset = 1'b1;
        a_req0_valid = 1'b0; a_req1_valid = 1'b0; a_rsp_ready = 1'b1;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_rsp_ready = 1'b1;
        a_req0_src1 = '0; a_req0_src2 = '0; a_req1_src1 = '0; a_req1_src2 = '0;
        b_req0_src1 = '0; b_req0_src2 = '0; b_req1_src1 = '0; b_req1_src2 = '0;
        tick; tick;
        a_reset = 1'b0; b_reset = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_rsp_valid, a_rsp_id, a_mul_en, a_req0_ready, a_req1_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b expected 000000",
                     {a_busy, a_rsp_valid, a_rsp_id, a_mul_en, a_req0_ready, a_req1_ready});
        end
        checks++;
        if ({a_rsp_result, a_mul_src1, a_mul_src2} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data_a: got %h %h %h expected all zero", a_rsp_result, a_mul_src1, a_mul_src2);
        end
        checks++;
        if ({b_busy, b_rsp_valid, b_mul_en, b_rsp_result} !== 35'h0) begin
            errors++;
            $display("FAIL reset_b: got %b %b %b %h expected zero", b_busy, b_rsp_valid, b_mul_en, b_rsp_result);
        end
    endtask

    task automatic test_single_req0;
        a_req0_valid = 1'b1; a_req0_src1 = 32'h0001_0003; a_req0_src2 = 32'h0002_0005;
        #1;
        checks++;
        if ({a_req0_ready, a_req1_ready} !== 2'b10) begin
            errors++; $display("FAIL s1_ready: got %b expected 10", {a_req0_ready, a_req1_ready});
        end
        tick;
        a_req0_valid = 1'b0; a_req0_src1 = '1; a_req0_src2 = '1;
        #1;
        checks++;
        if ({a_mul_src1, a_mul_src2} !== {32'h0001_0003, 32'h0002_0005}) begin
            errors++; $display("FAIL s1_mul_src: got %h %h expected 00010003 00020005", a_mul_src1, a_mul_src2);
        end
        checks++;
        if ({a_busy, a_mul_en, a_rsp_valid} !== 3'b110) begin
            errors++; $display("FAIL s1_wait: got %b expected 110", {a_busy, a_mul_en, a_rsp_valid});
        end
        tick;
        checks++;
        if ({a_busy, a_mul_en, a_rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL s1_combine: got %b expected 100", {a_busy, a_mul_en, a_rsp_valid});
        end
        tick;
        checks++;
        if ({a_rsp_valid, a_rsp_id, a_rsp_result} !== {1'b1, 1'b0, 32'h000B_000F}) begin
            errors++; $display("FAIL s1_resp: got %b %b %h expected 1 0 000b000f", a_rsp_valid, a_rsp_id, a_rsp_result);
        end
        tick;
        checks++;
        if ({a_busy, a_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL s1_idle: got %b expected 00", {a_busy, a_rsp_valid});
        end
    endtask

    task automatic test_wrap_req1;
        a_req1_valid = 1'b1; a_req1_src1 = 32'hFFFF_FFFF; a_req1_src2 = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({a_req0_ready, a_req1_ready} !== 2'b01) begin
            errors++; $display("FAIL s2_ready: got %b expected 01", {a_req0_ready, a_req1_ready});
        end
        tick;
        a_req1_valid = 1'b0;
        tick; tick;
        checks++;
        if ({a_rsp_valid, a_rsp_id, a_rsp_result} !== {1'b1, 1'b1, 32'h0000_0001}) begin
            errors++; $display("FAIL s2_resp: got %b %b %h expected 1 1 00000001", a_rsp_valid, a_rsp_id, a_rsp_result);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic exp_id;
        a_reset = 1'b1;
        tick;
        a_reset = 1'b0;
        a_req0_valid = 1'b1; a_req0_src1 = 32'd3; a_req0_src2 = 32'd4;
        a_req1_valid = 1'b1; a_req1_src1 = 32'd5; a_req1_src2 = 32'd6;
        a_rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            checks++;
            if ({a_req0_ready, a_req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, {a_req0_ready, a_req1_ready},
                                   (exp_id ? 2'b01 : 2'b10));
            end
            tick;
            checks++;
            if ({a_req0_ready, a_req1_ready} !== 2'b00) begin
                errors++; $display("FAIL rr_busy_ready%0d: got %b expected 00", k, {a_req0_ready, a_req1_ready});
            end
            tick; tick;
            checks++;
            if ({a_rsp_valid, a_rsp_id} !== {1'b1, exp_id}) begin
                errors++; $display("FAIL rr_id%0d: got %b %b expected 1 %b", k, a_rsp_valid, a_rsp_id, exp_id);
            end
            checks++;
            if (a_rsp_result !== (exp_id ? 32'd30 : 32'd12)) begin
                errors++; $display("FAIL rr_result%0d: got %0d expected %0d", k, a_rsp_result, (exp_id ? 30 : 12));
            end
            tick;
        end
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        a_rsp_ready = 1'b0;
        a_req1_valid = 1'b1; a_req1_src1 = 32'h10; a_req1_src2 = 32'h10;
        #1;
        checks++;
        if ({a_req0_ready, a_req1_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_accept: got %b expected 01", {a_req0_ready, a_req1_ready});
        end
        tick;
        a_req1_valid = 1'b0;
        tick; tick;
        a_req0_valid = 1'b1; a_req1_valid = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({a_rsp_valid, a_mul_en, a_req0_ready, a_req1_ready, a_busy} !== 5'b10001) begin
                errors++; $display("FAIL bp_ctrl%0d: got %b expected 10001", c,
                                   {a_rsp_valid, a_mul_en, a_req0_ready, a_req1_ready, a_busy});
            end
            checks++;
            if ({a_rsp_id, a_rsp_result} !== {1'b1, 32'h0000_0100}) begin
                errors++; $display("FAIL bp_hold%0d: got %b %h expected 1 00000100", c, a_rsp_id, a_rsp_result);
            end
            tick;
        end
        a_rsp_ready = 1'b1; a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        #1;
        checks++;
        if (a_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release: got %b expected 1", a_rsp_valid);
        end
        tick;
        checks++;
        if ({a_busy, a_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL bp_idle: got %b expected 00", {a_busy, a_rsp_valid});
        end
    endtask

    task automatic test_reset_mid_wait;
        b_rsp_ready = 1'b1;
        b_req0_valid = 1'b1; b_req0_src1 = 32'h0000_1234; b_req0_src2 = 32'h0000_0100;
        #1;
        checks++;
        if (b_req0_ready !== 1'b1) begin
            errors++; $display("FAIL rw_accept: got %b expected 1", b_req0_ready);
        end
        tick;
        b_req0_valid = 1'b0;
        tick;
        checks++;
        if ({b_busy, b_mul_en} !== 2'b11) begin
            errors++; $display("FAIL rw_wait2: got %b expected 11", {b_busy, b_mul_en});
        end
        b_reset = 1'b1;
        tick;
        b_reset = 1'b0;
        #1;
        checks++;
        if ({b_busy, b_rsp_valid, b_rsp_id, b_mul_en, b_req0_ready, b_req1_ready} !== 6'b0) begin
            errors++; $display("FAIL rw_ctrl: got %b expected 000000",
                               {b_busy, b_rsp_valid, b_rsp_id, b_mul_en, b_req0_ready, b_req1_ready});
        end
        checks++;
        if ({b_rsp_result, b_mul_src1, b_mul_src2} !== 96'h0) begin
            errors++; $display("FAIL rw_data: got %h %h %h expected all zero", b_rsp_result, b_mul_src1, b_mul_src2);
        end
        b_req0_valid = 1'b1; b_req0_src1 = 32'd7; b_req0_src2 = 32'd9;
        #1;
        checks++;
        if (b_req0_ready !== 1'b1) begin
            errors++; $display("FAIL rw_reaccept: got %b expected 1", b_req0_ready);
        end
        tick;
        b_req0_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            checks++;
            if (b_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rw_no_rsp%0d: got %b expected 0", c, b_rsp_valid);
            end
            tick;
        end
        checks++;
        if ({b_rsp_valid, b_rsp_id, b_rsp_result} !== {1'b1, 1'b0, 32'd63}) begin
            errors++; $display("FAIL rw_resp: got %b %b %0d expected 1 0 63", b_rsp_valid, b_rsp_id, b_rsp_result);
        end
        tick;
    endtask

    task automatic test_latency3;
        logic [8:0]  en_mask;
        int          first_valid;
        logic [31:0] res;
        en_mask = '0; first_valid = -1; res = '0;
        b_rsp_ready = 1'b1;
        b_req0_valid = 1'b1; b_req0_src1 = 32'd7; b_req0_src2 = 32'd9;
        #1;
        checks++;
        if (b_req0_ready !== 1'b1) begin
            errors++; $display("FAIL l3_accept: got %b expected 1", b_req0_ready);
        end
        tick;
        b_req0_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (b_mul_en === 1'b1) en_mask[c] = 1'b1;
            if (b_rsp_valid === 1'b1 && first_valid < 0) begin
                first_valid = c;
                res = b_rsp_result;
            end
            tick;
        end
        checks++;
        if (en_mask !== 9'b0_0000_1110) begin
            errors++; $display("FAIL l3_en_cycles: got %b expected 000001110", en_mask);
        end
        checks++;
        if (first_valid != 5) begin
            errors++; $display("FAIL l3_latency: got %0d expected 5", first_valid);
        end
        checks++;
        if (res !== 32'd63) begin
            errors++; $display("FAIL l3_result: got %0d expected 63", res);
        end
        checks++;
        if (b_busy !== 1'b0) begin
            errors++; $display("FAIL l3_idle: got %b expected 0", b_busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_req0;
        test_wrap_req1;
        test_round_robin;
        test_backpressure;
        test_reset_mid_wait;
        test_latency3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
